// File: rtl/median_seq_pkg.sv
// Shared types and constants for the median window sequencer.
package median_seq_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic [1:0] MODE_MEDIAN = 2'b00;
  localparam logic [1:0] MODE_FILTER = 2'b01;
  localparam logic [1:0] MODE_TRANSP = 2'b10;

  localparam int WIN_SIZE = 8;

  // The unused code 11 behaves as median.
  function automatic logic [1:0] map_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? MODE_MEDIAN : mode;
  endfunction

endpackage

// File: rtl/median_window_sequencer.sv
// Median window sequencer: streams samples into the median core's 8-entry
// register file, waits out the core latency, and returns the core output as
// a valid/ready result.
//
// Build option: SLIDING_WINDOW_EN -- after the first full window, every
// accepted sample replaces the oldest slot and yields one result.
// Without it, one result is produced per 8 accepted samples.
//
// state | meaning
// FILL  | accepting samples, one core register write per accepted beat
// WAIT  | counting down the core result latency after the last write
// DONE  | result held on r_data/r_valid until r_ready
module median_window_sequencer
  import median_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int RESULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] f_data_in,
  output logic [ADDR_W-1:0] f_reg_addr,
  output logic              f_wr_enable,
  output logic [1:0]        f_out_select,
  input  logic [DATA_W-1:0] f_data_out,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  input  logic              r_ready
);

  localparam logic [3:0] LAT_LOAD = 4'(RESULT_LAT - 1);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [3:0]        lat_cnt;
  logic              accept;
  logic              last_beat;
  logic              lat_done;

  assign accept   = s_valid & s_ready;
  assign lat_done = (lat_cnt == 4'd0);

`ifdef SLIDING_WINDOW_EN
  logic primed;

  // Once a full window exists, every sample closes a window.
  assign last_beat = (&wr_ptr) | primed;

  // Remember that the core holds a complete window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  primed <= 1'b0;
    else if (accept && &wr_ptr) primed <= 1'b1;
  end
`else
  assign last_beat = &wr_ptr;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (accept && last_beat) state_nxt = WAIT;
      WAIT:    if (lat_done)            state_nxt = DONE;
      DONE:    if (r_ready)             state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Core write port, window pointer and sample handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready      <= 1'b0;
      wr_ptr       <= '0;
      f_wr_enable  <= 1'b0;
      f_reg_addr   <= '0;
      f_data_in    <= '0;
      f_out_select <= MODE_MEDIAN;
    end else begin
      // s_ready tracks the state being entered, so it drops right after the
      // closing beat and rises one cycle after the result is taken.
      s_ready     <= (state_nxt == FILL);
      f_wr_enable <= 1'b0;
      if (accept) begin
        f_wr_enable <= 1'b1;
        f_reg_addr  <= wr_ptr;
        f_data_in   <= s_data;
        wr_ptr      <= wr_ptr + 1'b1;
        if (wr_ptr == '0) f_out_select <= map_mode(cfg_mode);
      end
    end
  end

  // Latency countdown and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt <= 4'd0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (accept && last_beat) lat_cnt <= LAT_LOAD;
      if (state == WAIT) begin
        if (lat_done) begin
          r_data  <= f_data_out;
          r_valid <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
      if (state == DONE && r_ready) r_valid <= 1'b0;
    end
  end

endmodule
